// File: rtl/sudoku_ctrl_if.sv
// Control/status bundle between the sudoku game controller, the button front end and the dp datapath.
interface sudoku_ctrl_if #(
   parameter int unsigned MOVE_W = 8
);
   // Front-end strobes and selects
   logic              start;
   logic [1:0]        diff_sel;
   logic [3:0]        cell_sel;
   logic [1:0]        val_sel;
   logic              enter;
   logic              submit;
   logic              retry;
   // Datapath status
   logic [15:0]       fill_flag;
   logic              solved;
   // Controller outputs
   logic              set_board;
   logic              register_inp_flag;
   logic              dp_check;
   logic              try_again_flag;
   logic              won;
   logic [1:0]        difficulty;
   logic [3:0]        ridx_a;
   logic [3:0]        ridx_b;
   logic [3:0]        reg_choose;
   logic [1:0]        value_inp;
   logic              busy;
   logic              err;
   logic [MOVE_W-1:0] moves;

   // Controller side
   modport master (
      input  start, diff_sel, cell_sel, val_sel, enter, submit, retry, fill_flag, solved,
      output set_board, register_inp_flag, dp_check, try_again_flag, won, difficulty,
             ridx_a, ridx_b, reg_choose, value_inp, busy, err, moves
   );

   // Environment side (front end + datapath)
   modport slave (
      output start, diff_sel, cell_sel, val_sel, enter, submit, retry, fill_flag, solved,
      input  set_board, register_inp_flag, dp_check, try_again_flag, won, difficulty,
             ridx_a, ridx_b, reg_choose, value_inp, busy, err, moves
   );
endinterface

// File: rtl/sudoku_ctrl.sv
// Game-sequencing controller: turns user strobes into single-cycle dp control pulses.
module sudoku_ctrl #(
   parameter logic [7:0]  LFSR_SEED = 8'hA5,
   parameter int unsigned MOVE_W    = 8
) (
   input logic           clka,
   input logic           restart_n,
   sudoku_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      IDLE, SET, SETTLE, PLAY, WRITE, CHECK, EVAL, WON, FAIL, RETRY
   } state_t;

   state_t            state, state_nxt;
   logic [7:0]        lfsr;
   logic              lfsr_fb;
   logic [3:0]        ridx_b_c;
   logic [15:0]       given_mask;
   logic              start_acc, write_acc, err_nxt, busy_nxt;

   logic              set_board_q, register_inp_flag_q, dp_check_q, try_again_flag_q;
   logic              won_q, busy_q, err_q;
   logic [1:0]        difficulty_q, value_inp_q;
   logic [3:0]        ridx_a_q, ridx_b_q, reg_choose_q;
   logic [MOVE_W-1:0] moves_q;

   // Feedback for x^8+x^6+x^5+x^4+1; second seed index is forced away from the first
   always_comb begin
      lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
      ridx_b_c = (lfsr[3:0] == lfsr[7:4]) ? (lfsr[7:4] ^ 4'h1) : lfsr[7:4];
   end

   // Free-running seed LFSR
   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) lfsr <= LFSR_SEED;
      else            lfsr <= {lfsr[6:0], lfsr_fb};
   end

   // State register
   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) state <= IDLE;
      else            state <= state_nxt;
   end

   // Next state and strobe acceptance; busy states ignore every strobe
   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      write_acc = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE:   if (bus.start) start_acc = 1'b1;
         SET:    state_nxt = SETTLE;
         SETTLE: state_nxt = PLAY;
         PLAY: begin
            if (bus.start) begin
               start_acc = 1'b1;
            end else if (bus.submit) begin
               if (&bus.fill_flag) state_nxt = CHECK;
               else                err_nxt   = 1'b1;
            end else if (bus.enter) begin
               if (!given_mask[bus.cell_sel]) begin
                  write_acc = 1'b1;
                  state_nxt = WRITE;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         WRITE:  state_nxt = PLAY;
         CHECK:  state_nxt = EVAL;
         EVAL:   state_nxt = bus.solved ? WON : FAIL;
         WON:    if (bus.start) start_acc = 1'b1;
         FAIL: begin
            if (bus.start)      start_acc = 1'b1;
            else if (bus.retry) state_nxt = RETRY;
         end
         RETRY:  state_nxt = PLAY;
         default: state_nxt = IDLE;
      endcase
      if (start_acc) state_nxt = SET;
      busy_nxt = state_nxt inside {SET, SETTLE, WRITE, CHECK, EVAL};
   end

   // Registered control pulses and status, aligned with the state they belong to
   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         set_board_q         <= 1'b0;
         register_inp_flag_q <= 1'b0;
         dp_check_q          <= 1'b0;
         try_again_flag_q    <= 1'b0;
         won_q               <= 1'b0;
         busy_q              <= 1'b0;
         err_q               <= 1'b0;
      end else begin
         set_board_q         <= (state_nxt == SET);
         register_inp_flag_q <= (state_nxt == WRITE);
         dp_check_q          <= (state_nxt == CHECK);
         try_again_flag_q    <= (state_nxt == RETRY);
         won_q               <= (state_nxt == WON);
         busy_q              <= busy_nxt;
         err_q               <= err_nxt;
      end
   end

   // Game setup, entry latches, given-cell mask and saturating move counter
   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         difficulty_q <= 2'd0;
         ridx_a_q     <= 4'd0;
         ridx_b_q     <= 4'd0;
         reg_choose_q <= 4'd0;
         value_inp_q  <= 2'd0;
         given_mask   <= 16'd0;
         moves_q      <= '0;
      end else begin
         if (start_acc) begin
            difficulty_q <= bus.diff_sel;
            ridx_a_q     <= lfsr[3:0];
            ridx_b_q     <= ridx_b_c;
         end
         if (write_acc) begin
            reg_choose_q <= bus.cell_sel;
            value_inp_q  <= bus.val_sel;
         end
         if (state == SETTLE) begin
            given_mask <= bus.fill_flag;
            moves_q    <= '0;
         end else if (state == WRITE) begin
            if (moves_q != {MOVE_W{1'b1}}) moves_q <= moves_q + MOVE_W'(1);
         end else if (state == RETRY) begin
            moves_q <= '0;
         end
      end
   end

   assign bus.set_board         = set_board_q;
   assign bus.register_inp_flag = register_inp_flag_q;
   assign bus.dp_check          = dp_check_q;
   assign bus.try_again_flag    = try_again_flag_q;
   assign bus.won               = won_q;
   assign bus.busy              = busy_q;
   assign bus.err               = err_q;
   assign bus.difficulty        = difficulty_q;
   assign bus.ridx_a            = ridx_a_q;
   assign bus.ridx_b            = ridx_b_q;
   assign bus.reg_choose        = reg_choose_q;
   assign bus.value_inp         = value_inp_q;
   assign bus.moves             = moves_q;

endmodule

// File: tb/tb_sudoku_ctrl.sv
// Self-checking bench for sudoku_ctrl: transaction-level game model plus directed scenarios.
module tb_sudoku_ctrl;

   localparam logic [7:0]  SEED = 8'hA5;
   localparam int unsigned MW   = 8;

   localparam int G_IDLE = 0, G_PLAY = 1, G_WON = 2, G_FAIL = 3;
   localparam int K_START = 0, K_WRITE = 1, K_CHECK = 2, K_RETRY = 3;

   logic clka      = 1'b0;
   logic restart_n = 1'b0;

   sudoku_ctrl_if #(.MOVE_W(MW)) bus ();

   sudoku_ctrl #(.LFSR_SEED(SEED), .MOVE_W(MW)) dut (
      .clka      (clka),
      .restart_n (restart_n),
      .bus       (bus.master)
   );

   always #5 clka = ~clka;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: game phase + countdown of pending work ----------------
   int          game, pend, kind;
   logic [7:0]  m_lfsr, l_old;
   logic [15:0] m_mask;
   logic        m_set, m_reg, m_chk, m_try, m_won, m_busy, m_err;
   logic [1:0]  m_diff, m_val;
   logic [3:0]  m_ra, m_rb, m_cell;
   logic [7:0]  m_moves;

   always @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         game = G_IDLE; pend = 0; kind = K_START;
         m_lfsr = SEED; m_mask = '0;
         m_set = 0; m_reg = 0; m_chk = 0; m_try = 0; m_won = 0; m_busy = 0; m_err = 0;
         m_diff = 0; m_val = 0; m_ra = 0; m_rb = 0; m_cell = 0; m_moves = 0;
      end else begin
         l_old  = m_lfsr;
         m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
         m_set = 0; m_reg = 0; m_chk = 0; m_try = 0; m_err = 0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               case (kind)
                  K_START: begin m_mask = bus.fill_flag; m_moves = 0; game = G_PLAY; end
                  K_WRITE: if (m_moves != 8'hFF) m_moves = m_moves + 8'd1;
                  K_CHECK: begin game = bus.solved ? G_WON : G_FAIL; m_won = bus.solved; end
                  default: m_moves = 0;
               endcase
            end
         end else if (bus.start) begin
            m_diff = bus.diff_sel;
            m_ra   = l_old[3:0];
            m_rb   = (l_old[3:0] == l_old[7:4]) ? (l_old[7:4] ^ 4'h1) : l_old[7:4];
            m_won  = 0; m_set = 1; pend = 2; kind = K_START; game = G_IDLE;
         end else if (game == G_PLAY && bus.submit) begin
            if (bus.fill_flag == 16'hFFFF) begin m_chk = 1; pend = 2; kind = K_CHECK; game = G_IDLE; end
            else m_err = 1;
         end else if (game == G_PLAY && bus.enter) begin
            if (m_mask[bus.cell_sel] == 1'b0) begin
               m_cell = bus.cell_sel; m_val = bus.val_sel; m_reg = 1; pend = 1; kind = K_WRITE;
            end else m_err = 1;
         end else if (game == G_FAIL && bus.retry) begin
            m_try = 1; pend = 1; kind = K_RETRY; game = G_PLAY;
         end
         m_busy = (pend > 0) && (kind != K_RETRY);
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clka) begin
      chk("set_board",  32'(bus.set_board),         32'(m_set));
      chk("reg_flag",   32'(bus.register_inp_flag), 32'(m_reg));
      chk("dp_check",   32'(bus.dp_check),          32'(m_chk));
      chk("try_again",  32'(bus.try_again_flag),    32'(m_try));
      chk("won",        32'(bus.won),               32'(m_won));
      chk("busy",       32'(bus.busy),              32'(m_busy));
      chk("err",        32'(bus.err),               32'(m_err));
      chk("difficulty", 32'(bus.difficulty),        32'(m_diff));
      chk("ridx_a",     32'(bus.ridx_a),            32'(m_ra));
      chk("ridx_b",     32'(bus.ridx_b),            32'(m_rb));
      chk("reg_choose", 32'(bus.reg_choose),        32'(m_cell));
      chk("value_inp",  32'(bus.value_inp),         32'(m_val));
      chk("moves",      32'(bus.moves),             32'(m_moves));
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clka);
   endtask

   task automatic chk_zero(input string nm);
      chk(nm, 32'({bus.set_board, bus.register_inp_flag, bus.dp_check, bus.try_again_flag,
                   bus.won, bus.busy, bus.err, bus.difficulty, bus.ridx_a, bus.ridx_b,
                   bus.reg_choose, bus.value_inp, bus.moves}), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   logic [7:0] snap;
   bit         found;

   initial begin
      bus.start = 0; bus.diff_sel = 0; bus.cell_sel = 0; bus.val_sel = 0;
      bus.enter = 0; bus.submit = 0; bus.retry = 0; bus.fill_flag = '0; bus.solved = 0;
      cyc(2);
      chk_zero("reset_outputs");

      // First edge after release accepts start with the LFSR still at the seed
      bus.start = 1; bus.diff_sel = 2'b10; restart_n = 1;
      cyc(1); bus.start = 0; bus.fill_flag = 16'h0F0F;
      chk("lit_set_board", 32'(bus.set_board), 32'd1);
      chk("lit_difficulty", 32'(bus.difficulty), 32'd2);
      chk("lit_ridx_a", 32'(bus.ridx_a), 32'h5);
      chk("lit_ridx_b", 32'(bus.ridx_b), 32'hA);
      chk("lit_busy0", 32'(bus.busy), 32'd1);
      cyc(1);
      chk("lit_set_board_end", 32'(bus.set_board), 32'd0);
      chk("lit_busy1", 32'(bus.busy), 32'd1);
      cyc(1);
      chk("lit_busy_play", 32'(bus.busy), 32'd0);

      // Enter on a given cell is rejected
      bus.enter = 1; bus.cell_sel = 4'd2; bus.val_sel = 2'd1;
      cyc(1); bus.enter = 0;
      chk("lit_err_given", 32'(bus.err), 32'd1);
      chk("lit_noreg_given", 32'(bus.register_inp_flag), 32'd0);
      cyc(1);
      chk("lit_err_once", 32'(bus.err), 32'd0);

      // Enter on a free cell
      bus.enter = 1; bus.cell_sel = 4'd4; bus.val_sel = 2'd3;
      cyc(1); bus.enter = 0;
      chk("lit_reg_choose", 32'(bus.reg_choose), 32'd4);
      chk("lit_value_inp", 32'(bus.value_inp), 32'd3);
      chk("lit_reg_pulse", 32'(bus.register_inp_flag), 32'd1);
      cyc(1);
      chk("lit_moves1", 32'(bus.moves), 32'd1);

      // Submit on a non-full board is rejected, then a solved check
      bus.fill_flag = 16'h7FFF; bus.submit = 1;
      cyc(1);
      chk("lit_err_submit", 32'(bus.err), 32'd1);
      chk("lit_nocheck", 32'(bus.dp_check), 32'd0);
      bus.fill_flag = 16'hFFFF; bus.solved = 1;
      cyc(1); bus.submit = 0;
      chk("lit_dp_check", 32'(bus.dp_check), 32'd1);
      cyc(2);
      chk("lit_won", 32'(bus.won), 32'd1);
      bus.enter = 1; bus.submit = 1; bus.retry = 1;
      cyc(1); bus.enter = 0; bus.submit = 0; bus.retry = 0;
      cyc(2);
      chk("lit_won_hold", 32'(bus.won), 32'd1);
      chk("lit_no_err_won", 32'(bus.err), 32'd0);

      // New game, one write, then a failed check and retry
      bus.start = 1; bus.diff_sel = 2'b01; bus.fill_flag = 16'h0F0F;
      cyc(1); bus.start = 0;
      chk("lit_won_clr", 32'(bus.won), 32'd0);
      cyc(2);
      bus.enter = 1; bus.cell_sel = 4'd4; bus.val_sel = 2'd1;
      cyc(1); bus.enter = 0;
      cyc(1);
      bus.fill_flag = 16'hFFFF; bus.solved = 0; bus.submit = 1;
      cyc(1); bus.submit = 0;
      cyc(2);
      chk("lit_fail_won", 32'(bus.won), 32'd0);
      chk("lit_fail_busy", 32'(bus.busy), 32'd0);
      bus.retry = 1;
      cyc(1); bus.retry = 0;
      chk("lit_try_again", 32'(bus.try_again_flag), 32'd1);
      cyc(1);
      chk("lit_try_once", 32'(bus.try_again_flag), 32'd0);
      chk("lit_moves_retry", 32'(bus.moves), 32'd0);
      bus.enter = 1; bus.cell_sel = 4'd5; bus.val_sel = 2'd2;
      cyc(1); bus.enter = 0;
      chk("lit_reg_after_retry", 32'(bus.register_inp_flag), 32'd1);
      chk("lit_cell_after_retry", 32'(bus.reg_choose), 32'd5);
      cyc(1);

      // Reset during a register_inp_flag pulse
      bus.enter = 1; bus.cell_sel = 4'd6;
      cyc(1); bus.enter = 0;
      #2 restart_n = 0;
      #1 chk_zero("async_rst_write");
      cyc(1); restart_n = 1;
      bus.enter = 1; bus.submit = 1; bus.fill_flag = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("lit_no_pulse_idle", 32'({bus.register_inp_flag, bus.dp_check, bus.err}), 32'd0);
      end
      bus.enter = 0; bus.submit = 0;

      // Reset during a dp_check pulse
      bus.start = 1;
      cyc(1); bus.start = 0;
      cyc(2);
      bus.submit = 1; bus.solved = 1;
      cyc(1); bus.submit = 0;
      chk("lit_dp_check2", 32'(bus.dp_check), 32'd1);
      #2 restart_n = 0;
      #1 chk_zero("async_rst_check");
      cyc(1); restart_n = 1;
      cyc(2);

      // Saturation: enter held high gives one write every two cycles
      bus.start = 1; bus.fill_flag = 16'h0000;
      cyc(1); bus.start = 0;
      cyc(2);
      bus.enter = 1; bus.cell_sel = 4'd1; bus.val_sel = 2'd2;
      cyc(600); bus.enter = 0;
      cyc(2);
      chk("lit_moves_sat", 32'(bus.moves), 32'hFF);

      // start beats submit and enter
      bus.fill_flag = 16'hFFFF;
      bus.start = 1; bus.submit = 1; bus.enter = 1; bus.cell_sel = 4'd3;
      cyc(1); bus.start = 0; bus.submit = 0; bus.enter = 0;
      chk("lit_prio_set", 32'(bus.set_board), 32'd1);
      chk("lit_prio_other", 32'({bus.register_inp_flag, bus.dp_check, bus.err}), 32'd0);
      bus.fill_flag = 16'h0000;
      cyc(3);

      // Start when the LFSR nibbles collide
      found = 0;
      for (int i = 0; i < 600 && !found; i++) begin
         if (m_lfsr[3:0] == m_lfsr[7:4]) found = 1;
         else cyc(1);
      end
      chk("collision_found", 32'(found), 32'd1);
      if (found) begin
         snap = m_lfsr;
         bus.start = 1;
         cyc(1); bus.start = 0;
         chk("coll_ridx_a", 32'(bus.ridx_a), 32'(snap[3:0]));
         chk("coll_ridx_b", 32'(bus.ridx_b), 32'(snap[7:4] ^ 4'h1));
      end
      cyc(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
